// File: rtl/mem_bus_arb.sv
// Shared external SRAM/PSRAM bus arbiter: picks one of CH requesters, runs a timed
// CE/OE/WE access on the pins and returns a one-cycle ack (with read data on reads).
//
// state  | meaning
// IDLE   | bus released, arbitrating pending requests
// SETUP  | CE low, address/byte lanes (and write data) presented
// ACCESS | OE or WE low for WAIT_RD / WAIT_WR cycles
// HOLD   | strobe released, CE/address/data still held, ack pulsed
module mem_bus_arb #(
    parameter int CH      = 3,
    parameter int AW      = 23,
    parameter int DW      = 8,
    parameter int WAIT_RD = 3,
    parameter int WAIT_WR = 3,
    parameter int PRIO0   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     req,
    input  logic [CH-1:0]     we,
    input  logic [CH*AW-1:0]  addr,
    input  logic [CH*DW-1:0]  wdat,
    output logic [CH-1:0]     ack,
    output logic [DW-1:0]     rdat,
    output logic              busy,
    output logic [2:0]        gnt_id,
    output logic [AW-2:0]     mem_addr,
    output logic [DW-1:0]     mem_dato,
    output logic              mem_dat_oe,
    input  logic [DW-1:0]     mem_dati,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_ub_n,
    output logic              mem_lb_n
);

    localparam int CW   = $clog2(CH);
    localparam int WMAX = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
    localparam int TW   = $clog2(WMAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] rr;
    logic [CW-1:0] gnt;
    logic [CW-1:0] win;
    logic          found;
    logic          cur_we;
    logic [TW-1:0] cnt;
    int            idx;

    // Winner search: ch0 first under fixed priority, otherwise rr+1 upward with wrap.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (PRIO0 != 0 && req[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= CH; k++) begin
                idx = (int'(rr) + k) % CH;
                if (!found && req[idx]) begin
                    win   = CW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr         <= '0;
            gnt        <= '0;
            cur_we     <= 1'b0;
            cnt        <= '0;
            ack        <= '0;
            rdat       <= '0;
            busy       <= 1'b0;
            gnt_id     <= '0;
            mem_addr   <= '0;
            mem_dato   <= '0;
            mem_dat_oe <= 1'b0;
            mem_ce_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            mem_ub_n   <= 1'b1;
            mem_lb_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= SETUP;
                        gnt        <= win;
                        gnt_id     <= 3'(win);
                        busy       <= 1'b1;
                        cur_we     <= we[win];
                        mem_addr   <= addr[int'(win)*AW +: AW-1];
                        mem_ub_n   <= ~addr[int'(win)*AW + AW-1];
                        mem_lb_n   <= addr[int'(win)*AW + AW-1];
                        mem_dato   <= wdat[int'(win)*DW +: DW];
                        mem_dat_oe <= we[win];
                        mem_ce_n   <= 1'b0;
                        if (!(PRIO0 != 0 && win == '0))
                            rr <= win;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    cnt      <= cur_we ? TW'(WAIT_WR - 1) : TW'(WAIT_RD - 1);
                    mem_oe_n <= cur_we;
                    mem_we_n <= ~cur_we;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state    <= HOLD;
                        mem_oe_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        ack[gnt] <= 1'b1;
                        if (!cur_we)
                            rdat <= mem_dati;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    state      <= IDLE;
                    ack        <= '0;
                    busy       <= 1'b0;
                    mem_ce_n   <= 1'b1;
                    mem_dat_oe <= 1'b0;
                    mem_ub_n   <= 1'b1;
                    mem_lb_n   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Scoreboard bench for mem_bus_arb: dut_a runs with ch0 priority, dut_b fully round-robin.
// Pin read data is a fixed function of the address so every expected read value is known.
module tb_mem_bus_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  req, we, ack;
    logic [68:0] addr;
    logic [23:0] wdat;
    logic [7:0]  rdat, mem_dato, mem_dati;
    logic        busy, mem_dat_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;
    logic [2:0]  gnt_id;
    logic [21:0] mem_addr;

    logic [2:0]  req_b, we_b, ack_b;
    logic [68:0] addr_b;
    logic [23:0] wdat_b;
    logic [7:0]  rdat_b, mem_dato_b, mem_dati_b;
    logic        busy_b, mem_dat_oe_b, mem_ce_n_b, mem_oe_n_b, mem_we_n_b, mem_ub_n_b, mem_lb_n_b;
    logic [2:0]  gnt_id_b;
    logic [21:0] mem_addr_b;

    assign mem_dati   = mem_oe_n   ? 8'h00 : (mem_addr[7:0] ^ 8'h79);
    assign mem_dati_b = mem_oe_n_b ? 8'h00 : (mem_addr_b[7:0] ^ 8'h79);

    mem_bus_arb #(.CH(3), .AW(23), .DW(8), .WAIT_RD(3), .WAIT_WR(3), .PRIO0(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdat(wdat),
        .ack(ack), .rdat(rdat), .busy(busy), .gnt_id(gnt_id), .mem_addr(mem_addr),
        .mem_dato(mem_dato), .mem_dat_oe(mem_dat_oe), .mem_dati(mem_dati),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n)
    );

    mem_bus_arb #(.CH(3), .AW(23), .DW(8), .WAIT_RD(3), .WAIT_WR(3), .PRIO0(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .wdat(wdat_b),
        .ack(ack_b), .rdat(rdat_b), .busy(busy_b), .gnt_id(gnt_id_b), .mem_addr(mem_addr_b),
        .mem_dato(mem_dato_b), .mem_dat_oe(mem_dat_oe_b), .mem_dati(mem_dati_b),
        .mem_ce_n(mem_ce_n_b), .mem_oe_n(mem_oe_n_b), .mem_we_n(mem_we_n_b),
        .mem_ub_n(mem_ub_n_b), .mem_lb_n(mem_lb_n_b)
    );

    typedef struct {
        int          ch;
        logic        w;
        logic [22:0] a;
        logic [7:0]  d;
        int          lat;
        int          gap;
    } acc_t;

    acc_t sb_a[$];
    acc_t sb_b[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int          pend[3];
    int          issued[3];
    int          raise_cyc[3];
    logic [22:0] base_a[3];
    logic        base_w[3];
    logic [7:0]  base_d[3];
    logic [2:0]  ack_seen, b_seen;

    int         ce_cnt, hi_cnt, last_gap, st_cnt, do_cnt;
    logic [7:0] last_rdat;
    int         ce_b, hi_b, gap_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic setup_ch(input int c, input int n, input logic w, input logic [22:0] a,
                            input logic [7:0] d);
        pend[c] = n; issued[c] = 0; base_a[c] = a; base_w[c] = w; base_d[c] = d;
    endtask

    task automatic expect_acc(input int c, input logic w, input logic [22:0] a,
                              input logic [7:0] d, input int lat, input int gap);
        acc_t e;
        e.ch = c; e.w = w; e.a = a; e.d = d; e.lat = lat; e.gap = gap;
        sb_a.push_back(e);
    endtask

    task automatic drive();
        for (int c = 0; c < 3; c++) begin
            if (ack_seen[c]) begin req[c] = 1'b0; ack_seen[c] = 1'b0; end
            if (!req[c] && pend[c] > 0) begin
                addr[c*23 +: 23] = base_a[c] + 23'(issued[c]);
                we[c]            = base_w[c];
                wdat[c*8 +: 8]   = base_d[c];
                req[c]           = 1'b1;
                raise_cyc[c]     = cyc;
                pend[c]--;
                issued[c]++;
            end
            if (b_seen[c]) begin req_b[c] = 1'b0; b_seen[c] = 1'b0; end
        end
    endtask

    task automatic mon_a();
        acc_t e;
        if (!rst_n) begin
            ce_cnt = 0; hi_cnt = 0; st_cnt = 0; do_cnt = 0; last_rdat = 8'h00;
        end else begin
            chk("busy_vs_ce", busy, !mem_ce_n);
            chk("oe_conflict", mem_dat_oe && !mem_oe_n, 0);
            chk("idle_lanes", mem_ce_n ? {mem_ub_n, mem_lb_n, mem_dat_oe} : 3'b110, 3'b110);
            if (ack == 3'b000) chk("rdat_hold", rdat, last_rdat);
            if (!mem_ce_n) begin
                if (ce_cnt == 0) last_gap = hi_cnt;
                ce_cnt++; hi_cnt = 0;
                if (!mem_oe_n || !mem_we_n) st_cnt++;
                if (mem_dat_oe) do_cnt++;
            end else begin
                ce_cnt = 0; hi_cnt++; st_cnt = 0; do_cnt = 0;
            end
            if (ack != 3'b000) begin
                ack_seen = ack_seen | ack;
                if (sb_a.size() == 0) begin
                    chk("unexpected_ack", ack, 0);
                end else begin
                    e = sb_a.pop_front();
                    chk("ack_ch", ack, 1 << e.ch);
                    chk("gnt_id", gnt_id, e.ch);
                    chk("mem_addr", mem_addr, e.a[21:0]);
                    chk("ub_n", mem_ub_n, !e.a[22]);
                    chk("lb_n", mem_lb_n, e.a[22]);
                    chk("ce_window", ce_cnt, 5);
                    chk("strobe_len", st_cnt, 3);
                    chk("oe_n_hold", mem_oe_n, 1);
                    chk("we_n_hold", mem_we_n, 1);
                    if (e.w) begin
                        chk("mem_dato", mem_dato, e.d);
                        chk("dat_oe_cycles", do_cnt, 5);
                        chk("rdat_on_write", rdat, last_rdat);
                    end else begin
                        chk("rdat", rdat, e.a[7:0] ^ 8'h79);
                        chk("dat_oe_read", do_cnt, 0);
                        last_rdat = e.a[7:0] ^ 8'h79;
                    end
                    if (e.lat >= 0) chk("latency", cyc - raise_cyc[e.ch], e.lat);
                    if (e.gap >= 0) chk("idle_gap", last_gap, e.gap);
                end
            end
        end
    endtask

    task automatic mon_b();
        acc_t e;
        if (!rst_n) begin
            ce_b = 0; hi_b = 0;
        end else begin
            chk("b_busy_vs_ce", busy_b, !mem_ce_n_b);
            if (!mem_ce_n_b) begin
                if (ce_b == 0) gap_b = hi_b;
                ce_b++; hi_b = 0;
            end else begin
                ce_b = 0; hi_b++;
            end
            if (ack_b != 3'b000) begin
                b_seen = b_seen | ack_b;
                if (sb_b.size() == 0) begin
                    chk("b_unexpected_ack", ack_b, 0);
                end else begin
                    e = sb_b.pop_front();
                    chk("b_grant_order", ack_b, 1 << e.ch);
                    chk("b_gnt_id", gnt_id_b, e.ch);
                    chk("b_rdat", rdat_b, e.a[7:0] ^ 8'h79);
                    chk("b_ce_window", ce_b, 5);
                    if (e.gap >= 0) chk("b_idle_gap", gap_b, e.gap);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive();
        @(negedge clk);
        mon_a();
        mon_b();
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0 || req != 3'b000 || req_b != 3'b000 ||
                pend[0] != 0 || pend[1] != 0 || pend[2] != 0 || busy || busy_b) && n < max) begin
            step();
            n++;
        end
        if (n >= max) chk({tag, "_timeout"}, 1, 0);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req = '0; we = '0; addr = '0; wdat = '0;
        req_b = '0; we_b = '0; wdat_b = '0;
        addr_b = {23'h000053, 23'h400042, 23'h000031};
        ack_seen = '0; b_seen = '0;
        ce_cnt = 0; hi_cnt = 0; last_gap = 0; st_cnt = 0; do_cnt = 0; last_rdat = 8'h00;
        ce_b = 0; hi_b = 0; gap_b = 0;
        for (int c = 0; c < 3; c++) begin
            pend[c] = 0; issued[c] = 0; raise_cyc[c] = 0;
            base_a[c] = '0; base_w[c] = 1'b0; base_d[c] = '0;
        end

        repeat (3) step();
        chk("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 5'b11111);
        chk("rst_dat_oe", mem_dat_oe, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_rdat", rdat, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // ch1 read, then ch2 upper-lane write
        expect_acc(1, 1'b0, 23'h000123, 8'h00, 5, -1);
        setup_ch(1, 1, 1'b0, 23'h000123, 8'h00);
        wait_done("t1", 40);
        expect_acc(2, 1'b1, 23'h400010, 8'hC3, 5, -1);
        setup_ch(2, 1, 1'b1, 23'h400010, 8'hC3);
        wait_done("t2", 40);

        // all-round-robin instance, everyone requesting at once
        sb_b.push_back('{1, 1'b0, 23'h400042, 8'h00, -1, -1});
        sb_b.push_back('{2, 1'b0, 23'h000053, 8'h00, -1, 1});
        sb_b.push_back('{0, 1'b0, 23'h000031, 8'h00, -1, 1});
        req_b = 3'b111;
        wait_done("t3", 60);

        // ch1 back-to-back reads
        expect_acc(1, 1'b0, 23'h000200, 8'h00, 5, -1);
        expect_acc(1, 1'b0, 23'h000201, 8'h00, 5, 1);
        setup_ch(1, 2, 1'b0, 23'h000200, 8'h00);
        wait_done("t6", 60);

        // reset in the 2nd ACCESS cycle of a write
        setup_ch(2, 1, 1'b1, 23'h000077, 8'h3C);
        n = 0;
        while (!(st_cnt == 2 && !mem_we_n) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("t5_reach_access", 0, 1);
        rst_n = 1'b0;
        req = '0;
        for (int c = 0; c < 3; c++) pend[c] = 0;
        step();
        chk("t5_strobes", {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 5'b11111);
        chk("t5_dat_oe", mem_dat_oe, 0);
        chk("t5_ack", ack, 0);
        chk("t5_busy", busy, 0);
        chk("t5_gnt_id", gnt_id, 0);
        chk("t5_rdat", rdat, 0);
        chk("t5_mem_addr", mem_addr, 0);
        ack_seen = '0;
        rst_n = 1'b1;
        repeat (3) begin
            step();
            chk("t5_no_ack", ack, 0);
        end
        expect_acc(0, 1'b1, 23'h000055, 8'h99, 5, -1);
        setup_ch(0, 1, 1'b1, 23'h000055, 8'h99);
        wait_done("t5_post", 40);

        // ch0 priority with ch1/ch2 pending
        expect_acc(0, 1'b0, 23'h000100, 8'h00, 5, -1);
        expect_acc(0, 1'b0, 23'h000101, 8'h00, -1, 1);
        expect_acc(0, 1'b0, 23'h000102, 8'h00, -1, 1);
        expect_acc(1, 1'b0, 23'h400300, 8'h00, -1, 1);
        expect_acc(2, 1'b1, 23'h000400, 8'h6E, -1, 1);
        setup_ch(0, 3, 1'b0, 23'h000100, 8'h00);
        setup_ch(1, 1, 1'b0, 23'h400300, 8'h00);
        setup_ch(2, 1, 1'b1, 23'h000400, 8'h6E);
        wait_done("t4", 120);

        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
